// File: rtl/btn_stepper_pkg.sv
// ----------------------------------------------------------------------------
// btn_stepper_pkg
//   Shared definitions for the button-driven state stepper:
//     - clog2()        : ceiling log2 usable in constant expressions
//     - state_width()  : width of the state output, max(1, ceil(log2(n)))
//     - step_dir_e     : step direction taken in a given cycle
//     - decode_dir()   : maps the two rise strobes onto a step direction
//   Optional feature macro used by the conditioner: BTN_STEPPER_DEBOUNCE_EN
// ----------------------------------------------------------------------------
package btn_stepper_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // A state vector is never narrower than one bit.
  function automatic int state_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } step_dir_e;

  // Simultaneous rises cancel: the user pressed both buttons, so neither wins.
  function automatic step_dir_e decode_dir(input logic up_rise, input logic dn_rise);
    step_dir_e d;
    d = DIR_NONE;
    if (up_rise && !dn_rise) d = DIR_UP;
    if (dn_rise && !up_rise) d = DIR_DN;
    return d;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
//   Turns one raw asynchronous push-button into a single-cycle rise strobe:
//   two-flop synchroniser -> filtered level f -> rising-edge detect.
//
//   Build option BTN_STEPPER_DEBOUNCE_EN:
//     defined   : f only follows the synchronised level after it has differed
//                 from f for DB_CYCLES consecutive cycles.
//     undefined : f is a plain register of the synchronised level; DB_CYCLES
//                 is ignored and contact bounce may produce several rises.
//
//   Ports
//     clk    in   clock
//     rst    in   synchronous active-high reset, clears every flop
//     i_btn  in   raw asynchronous button level
//     o_rise out  one-cycle strobe on a 0->1 transition of f
// ----------------------------------------------------------------------------
module btn_conditioner
  import btn_stepper_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_s0;
  logic r_s1;
  logic r_f;
  logic r_f_d;

  // Metastability guard for the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_btn;
      r_s1 <= r_s0;
    end
  end

`ifdef BTN_STEPPER_DEBOUNCE_EN
  localparam int             CW       = (clog2(DB_CYCLES) < 1) ? 1 : clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Counts consecutive cycles where the synchronised level disagrees with f.
  // Any agreement restarts the count, so a pulse shorter than DB_CYCLES can
  // never reach CNT_LAST and f stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f   <= 1'b0;
      r_cnt <= '0;
    end else if (r_s1 == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_f   <= r_s1;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_f <= 1'b0;
    else     r_f <= r_s1;
  end

  // DB_CYCLES has no effect in this build.
  logic w_unused_db;
  assign w_unused_db = (DB_CYCLES > 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_f_d <= 1'b0;
    else     r_f_d <= r_f;
  end

  assign o_rise = r_f & ~r_f_d;

endmodule

// File: rtl/btn_state_stepper.sv
// ----------------------------------------------------------------------------
// btn_state_stepper
//   Up/down state counter of N_STATES states stepped by two raw push-buttons.
//   Each button is conditioned by btn_conditioner; a rise on btn_up steps the
//   state up, a rise on btn_dn steps it down, both together do nothing.
//   WRAP=1 wraps at both ends, WRAP=0 saturates (a saturated hold is not a
//   step). The state never leaves 0..N_STATES-1, also for non-power-of-two
//   N_STATES.
//
//   Build option BTN_STEPPER_DEBOUNCE_EN enables the per-button debounce
//   filter of DB_CYCLES cycles (see btn_conditioner).
//
//   Ports
//     clk     in   clock
//     rst     in   synchronous active-high reset
//     btn_up  in   raw asynchronous button, step up
//     btn_dn  in   raw asynchronous button, step down
//     state   out  current state, width max(1, ceil(log2(N_STATES)))
//     step    out  one-cycle strobe, high the cycle after state changed
//     at_max  out  state == N_STATES-1 (combinational)
//     at_min  out  state == 0 (combinational)
// ----------------------------------------------------------------------------
module btn_state_stepper
  import btn_stepper_pkg::*;
#(
  parameter int N_STATES  = 8,
  parameter int WRAP      = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             btn_up,
  input  logic                             btn_dn,
  output logic [state_width(N_STATES)-1:0] state,
  output logic                             step,
  output logic                             at_max,
  output logic                             at_min
);

  localparam int            SW     = state_width(N_STATES);
  localparam logic [SW-1:0] ST_MAX = SW'(N_STATES - 1);
  localparam logic [SW-1:0] ST_MIN = '0;

  logic          w_up_rise;
  logic          w_dn_rise;
  step_dir_e     w_dir;
  logic [SW-1:0] w_next;
  logic          w_chg;

  logic [SW-1:0] r_state;
  logic          r_chg;
  logic          r_step;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_up (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_up),
    .o_rise (w_up_rise)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_dn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_dn),
    .o_rise (w_dn_rise)
  );

  assign w_dir = decode_dir(w_up_rise, w_dn_rise);

  // Next state. The ends are compared explicitly rather than relying on
  // binary overflow, which keeps non-power-of-two ranges closed.
  always_comb begin
    w_next = r_state;
    w_chg  = 1'b0;
    case (w_dir)
      DIR_UP: begin
        if (r_state == ST_MAX) begin
          if (WRAP != 0) begin
            w_next = ST_MIN;
            w_chg  = 1'b1;
          end
        end else begin
          w_next = r_state + SW'(1);
          w_chg  = 1'b1;
        end
      end
      DIR_DN: begin
        if (r_state == ST_MIN) begin
          if (WRAP != 0) begin
            w_next = ST_MAX;
            w_chg  = 1'b1;
          end
        end else begin
          w_next = r_state - SW'(1);
          w_chg  = 1'b1;
        end
      end
      default: begin
        w_next = r_state;
        w_chg  = 1'b0;
      end
    endcase
  end

  // r_chg marks the edge that moved the state; step follows one edge later
  // so that downstream logic sees the strobe alongside a settled state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MIN;
      r_chg   <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_chg   <= w_chg;
      r_step  <= r_chg;
    end
  end

  assign state  = r_state;
  assign step   = r_step;
  assign at_max = (r_state == ST_MAX);
  assign at_min = (r_state == ST_MIN);

endmodule
